// File: rtl/tpu_host_ctrl.sv
// rtl/tpu_host_ctrl.sv - host sequencer: load A/B buffers, start TPU, drain C buffer to a stream
module tpu_host_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [7:0]   cfg_K,
    input  logic [7:0]   cfg_M,
    input  logic [7:0]   cfg_N,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [31:0]  ld_data,
    output logic         A_wr_en,
    output logic         B_wr_en,
    output logic [15:0]  A_index,
    output logic [15:0]  B_index,
    output logic [31:0]  A_data_in,
    output logic [31:0]  B_data_in,
    output logic [15:0]  C_index,
    input  logic [127:0] C_data_out,
    output logic         buf_owner,
    output logic         tpu_in_valid,
    output logic [7:0]   tpu_K,
    output logic [7:0]   tpu_M,
    output logic [7:0]   tpu_N,
    input  logic         tpu_busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT_HI,
        S_WAIT_LO, S_RD_ISSUE, S_RD_CAP, S_DONE
    } state_t;

    state_t       r_state, w_next;
    logic [15:0]  r_idx, r_na, r_nb, r_nc;
    logic [7:0]   r_k, r_m, r_n;
    logic [127:0] r_out_data;
    logic         r_cap_pend;
    logic         r_tpu_in_valid;
    logic [15:0]  w_m4, w_n4;
    logic         w_zero, w_a_last, w_b_last, w_c_last;

    assign w_m4     = ({8'd0, cfg_M} + 16'd3) >> 2;
    assign w_n4     = ({8'd0, cfg_N} + 16'd3) >> 2;
    assign w_zero   = (cfg_K == 8'd0) || (cfg_M == 8'd0) || (cfg_N == 8'd0);
    assign w_a_last = (r_idx == r_na - 16'd1);
    assign w_b_last = (r_idx == r_nb - 16'd1);
    assign w_c_last = (r_idx == r_nc - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cfg_ready = 1'b0;
        ld_ready  = 1'b0;
        A_wr_en   = 1'b0;
        B_wr_en   = 1'b0;
        A_index   = 16'd0;
        B_index   = 16'd0;
        A_data_in = 32'd0;
        B_data_in = 32'd0;
        C_index   = 16'd0;
        buf_owner = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_next = w_zero ? S_DONE : S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                ld_ready  = 1'b1;
                A_wr_en   = ld_valid;
                A_index   = r_idx;
                A_data_in = ld_data;
                if (ld_valid && w_a_last) begin
                    w_next = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                ld_ready  = 1'b1;
                B_wr_en   = ld_valid;
                B_index   = r_idx;
                B_data_in = ld_data;
                if (ld_valid && w_b_last) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                buf_owner = 1'b1;
                w_next    = S_WAIT_HI;
            end
            // a busy that lags the start pulse must not read as completion
            S_WAIT_HI: begin
                buf_owner = 1'b1;
                if (tpu_busy) begin
                    w_next = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                buf_owner = 1'b1;
                if (!tpu_busy) begin
                    w_next = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                C_index = r_idx;
                w_next  = S_RD_CAP;
            end
            S_RD_CAP: begin
                C_index   = r_idx;
                out_valid = 1'b1;
                out_last  = w_c_last;
                if (out_ready) begin
                    w_next = w_c_last ? S_DONE : S_RD_ISSUE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= 16'd0;
            r_na           <= 16'd0;
            r_nb           <= 16'd0;
            r_nc           <= 16'd0;
            r_k            <= 8'd0;
            r_m            <= 8'd0;
            r_n            <= 8'd0;
            r_out_data     <= 128'd0;
            r_cap_pend     <= 1'b0;
            r_tpu_in_valid <= 1'b0;
        end else begin
            r_tpu_in_valid <= (w_next == S_START);
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_k   <= cfg_K;
                        r_m   <= cfg_M;
                        r_n   <= cfg_N;
                        r_na  <= w_m4 * {8'd0, cfg_K};
                        r_nb  <= w_n4 * {8'd0, cfg_K};
                        r_nc  <= {8'd0, cfg_M} * w_n4;
                        r_idx <= 16'd0;
                    end
                end
                S_LOAD_A: begin
                    if (ld_valid) begin
                        r_idx <= w_a_last ? 16'd0 : r_idx + 16'd1;
                    end
                end
                S_LOAD_B: begin
                    if (ld_valid) begin
                        r_idx <= w_b_last ? 16'd0 : r_idx + 16'd1;
                    end
                end
                S_WAIT_LO: r_idx <= 16'd0;
                S_RD_ISSUE: r_cap_pend <= 1'b1;
                S_RD_CAP: begin
                    // read data is live only in the first RD_CAP cycle; hold a copy for stalls
                    if (r_cap_pend) begin
                        r_out_data <= C_data_out;
                        r_cap_pend <= 1'b0;
                    end
                    if (out_ready && !w_c_last) begin
                        r_idx <= r_idx + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign out_data     = r_cap_pend ? C_data_out : r_out_data;
    assign tpu_in_valid = r_tpu_in_valid;
    assign tpu_K        = r_k;
    assign tpu_M        = r_m;
    assign tpu_N        = r_n;

endmodule
